// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the fewcore boot-time instruction-memory loader.
package fewcore_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
module word_assembler
  import fewcore_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] idx;

  assign last = byte_en && (idx == 2'(WORD_BYTES - 1));

  // Bytes enter at the top so the first (least significant) byte ends up in [7:0].
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      idx        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= last;
      if (byte_en) begin
        idx  <= idx + 2'd1;
        word <= {byte_in, word[31:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream -> word writes, holds core until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
  import fewcore_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      stream,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = S_CSUM;
`else
  localparam state_t END_ST = S_DONE;
`endif

  state_t            state, state_n;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   wcnt_inc;
  logic [16:0]       n_ext;
  logic              accept, rearm, data_en, wlast, words_done;

  assign stream.in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                           (state == S_DATA) || (state == S_CSUM);
  assign accept     = stream.in_valid && stream.in_ready;
  assign rearm      = start && ((state == S_DONE) || (state == S_ERR));
  assign data_en    = accept && (state == S_DATA);
  assign n_ext      = {1'b0, stream.in_data, len_lo};
  assign wcnt_inc   = wcnt + 1'b1;
  assign words_done = (wcnt_inc == len);

  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign core_hold = (state != S_DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (rearm),
    .byte_en    (data_en),
    .byte_in    (stream.in_data),
    .last       (wlast),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN0;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_LEN0: if (accept) state_n = S_LEN1;
      S_LEN1: if (accept) begin
        if (n_ext > CAP)           state_n = S_ERR;
        else if (n_ext == 17'd0)   state_n = END_ST;
        else                       state_n = S_DATA;
      end
      S_DATA: if (wlast && words_done) state_n = END_ST;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_n = (stream.in_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (start) state_n = S_LEN0;
      default: state_n = S_ERR;
    endcase
  end

  // Length is bounded by CAP at S_LEN1, so wcnt never exceeds 2**ADDR_W and the address never wraps.
  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      len_lo    <= '0;
      len       <= '0;
      wcnt      <= '0;
      imem_addr <= '0;
    end else begin
      if (accept && state == S_LEN0) len_lo <= stream.in_data;
      if (accept && state == S_LEN1) len    <= n_ext[ADDR_W:0];
      if (wlast) begin
        imem_addr <= wcnt[ADDR_W-1:0];
        wcnt      <= wcnt_inc;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || rearm) csum <= '0;
    else if (data_en)   csum <= csum ^ stream.in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2): load, zero-length, overflow, gaps, reset mid-word, checksum.
module tb_imem_loader;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              imem_we, core_hold, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .stream     (bus.slave),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write log: captured from the DUT, compared against hand-computed constants.
  int          wr_n = 0;
  int          dbl = 0;
  logic        prev_we = 1'b0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  always @(posedge clk) begin
    if (imem_we && wr_n < 64) begin
      wa[wr_n] = 32'(imem_addr);
      wd[wr_n] = imem_wdata;
      wr_n++;
    end
    if (imem_we && prev_we) dbl++;
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1 chk("in_ready_on_send", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_basic(input int gap);
    int base, d0;
    logic [7:0] s [10];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    base = wr_n;
    d0 = dbl;
    for (int i = 0; i < 10; i++) send_byte(s[i], (i == 9) ? 0 : gap);
    chk("last_we", 32'(imem_we), 32'd1);
    chk("last_addr", 32'(imem_addr), 32'd1);
    chk("last_wdata", imem_wdata, 32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h2A, 0);
`endif
    chk("load_done", 32'(done), 32'd1);
    chk("load_hold", 32'(core_hold), 32'd0);
    @(posedge clk);
    #1;
    chk("load_nwr", 32'(wr_n - base), 32'd2);
    chk("load_a0", wa[base], 32'd0);
    chk("load_d0", wd[base], 32'h12345678);
    chk("load_a1", wa[base+1], 32'd1);
    chk("load_d1", wd[base+1], 32'hDEADBEEF);
    chk("load_single_pulse", 32'(dbl - d0), 32'd0);
    chk("load_rdy_after", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd1);

    load_basic(0);

    pulse_start();
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_hold", 32'(core_hold), 32'd1);
    chk("rearm_ready", 32'(bus.in_ready), 32'd1);

    // zero length
    base = wr_n;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    chk("zero_ready", 32'(bus.in_ready), 32'd0);
    chk("zero_nwr", 32'(wr_n - base), 32'd0);

    // overflow: 5 words > capacity 4
    pulse_start();
    base = wr_n;
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_hold", 32'(core_hold), 32'd1);
    chk("ovf_ready", 32'(bus.in_ready), 32'd0);
    chk("ovf_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 chk("ovf_nwr", 32'(wr_n - base), 32'd0);
    pulse_start();
    chk("ovf_clr_error", 32'(error), 32'd0);
    chk("ovf_clr_ready", 32'(bus.in_ready), 32'd1);

    // exactly capacity is accepted
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    chk("cap_error", 32'(error), 32'd0);
    chk("cap_ready", 32'(bus.in_ready), 32'd1);
    pulse_reset();

    load_basic(3);

    // reset mid-word
    pulse_start();
    base = wr_n;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_reset();
    @(negedge clk);
    chk("mid_nwr", 32'(wr_n - base), 32'd0);
    chk("mid_hold", 32'(core_hold), 32'd1);
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h04, 0);
`endif
    chk("mid2_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    chk("mid2_nwr", 32'(wr_n - base), 32'd1);
    chk("mid2_a0", wa[base], 32'd0);
    chk("mid2_d0", wd[base], 32'h04030201);

`ifdef LOADER_CHECKSUM_EN
    // checksum mismatch
    pulse_start();
    base = wr_n;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    chk("csum_error", 32'(error), 32'd1);
    chk("csum_hold", 32'(core_hold), 32'd1);
    chk("csum_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("csum_nwr", 32'(wr_n - base), 32'd1);
    chk("csum_d0", wd[base], 32'h04030201);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
